// File: rtl/debounce_pkg.sv
// Shared types and constants for the button debouncer.
// Holds the FSM state encoding and counter limits.
package debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } db_state_t;

  localparam int DB_CNT_MAX_DEF = 1_000_000;
  localparam int DB_MIN_CNT     = 2;

endpackage

// File: rtl/sync_2ff.sv
// Parameterised-depth synchroniser chain.
// Synchronous active-low reset clears every stage.
module sync_2ff #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] ff;

  always_ff @(posedge clk) begin
    if (!reset) begin
      ff <= '0;
    end else begin
      ff[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        ff[i] <= ff[i-1];
      end
    end
  end

  assign q = ff[DEPTH-1];

endmodule

// File: rtl/button_debounce.sv
// Counter-based push-button debouncer with clean level output.
// BUTTON_DEBOUNCE_SYNC2_EN selects a 2-flop input synchroniser.
module button_debounce
  import debounce_pkg::*;
#(
  parameter int CNT_MAX = DB_CNT_MAX_DEF,
  parameter int CNT_W   = $clog2(CNT_MAX)
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic db_out,
  output logic db_busy
);

`ifdef BUTTON_DEBOUNCE_SYNC2_EN
  localparam int SYNC_L = 2;
`else
  localparam int SYNC_L = 1;
`endif

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(CNT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_ONE =
    CNT_W'(1);

  logic             s;
  db_state_t        state_q;
  db_state_t        state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             db_q;
  logic             db_d;

  sync_2ff #(
    .DEPTH(SYNC_L)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (btn_in),
    .q    (s)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      db_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
    end
  end

  // Bounce abort is tested before count completion.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    db_d    = db_q;
    unique case (state_q)
      STABLE_LO: begin
        if (s) begin
          state_d = WAIT_HI;
          cnt_d   = '0;
        end
      end
      WAIT_HI: begin
        if (!s) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
          db_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STABLE_HI: begin
        if (!s) begin
          state_d = WAIT_LO;
          cnt_d   = '0;
        end
      end
      WAIT_LO: begin
        if (s) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
          db_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
        db_d    = 1'b0;
      end
    endcase
  end

  assign db_out  = db_q;
  assign db_busy = (state_q == WAIT_HI) ||
                   (state_q == WAIT_LO);

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench for button_debounce against a run-length model.
// Honours BUTTON_DEBOUNCE_SYNC2_EN for the synchroniser depth.
module tb_button_debounce;

  localparam int CM = 4;
`ifdef BUTTON_DEBOUNCE_SYNC2_EN
  localparam int L = 2;
`else
  localparam int L = 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn_in = 1'b0;
  logic db_out;
  logic db_busy;

  always #5 clk = ~clk;

  button_debounce #(
    .CNT_MAX(CM)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .btn_in (btn_in),
    .db_out (db_out),
    .db_busy(db_busy)
  );

  typedef struct {
    logic out;
    logic busy;
    int   edge_no;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  // Model: the debounced level flips once the FSM
  // has observed CM+1 consecutive opposite samples.
  bit   m_db = 1'b0;
  int   m_run = 0;
  bit   m_pipe[$];
  int   edge_no = 0;

  task automatic check_eq(
    input string name,
    input int act,
    input int exp
  );
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  task automatic step(input logic b, input logic r);
    bit s;
    exp_t e;
    btn_in = b;
    reset  = r;
    @(posedge clk);
    edge_no++;
    if (!r) begin
      m_pipe.delete();
      repeat (L) m_pipe.push_back(1'b0);
      m_db  = 1'b0;
      m_run = 0;
    end else begin
      s = m_pipe.pop_front();
      if (s != m_db) begin
        m_run++;
        if (m_run == CM + 1) begin
          m_db  = s;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      m_pipe.push_back(b);
    end
    e.out     = m_db;
    e.busy    = (m_run > 0);
    e.edge_no = edge_no;
    sb.push_back(e);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin : mon
      exp_t e;
      e = sb.pop_front();
      checks += 2;
      if (db_out !== e.out) begin
        failures++;
        $display("FAIL db_out edge %0d: got %b expected %b",
                 e.edge_no, db_out, e.out);
      end
      if (db_busy !== e.busy) begin
        failures++;
        $display("FAIL db_busy edge %0d: got %b expected %b",
                 e.edge_no, db_busy, e.busy);
      end
    end
  end

  task automatic measure(
    input string name,
    input logic lvl
  );
    int n;
    int busy_n;
    n = 0;
    busy_n = 0;
    do begin
      step(lvl, 1'b1);
      n++;
      if (db_busy) busy_n++;
    end while (db_out !== lvl && n < 100);
    check_eq({name, "_latency"}, n - 1, L + CM);
    check_eq({name, "_busy"}, busy_n, CM);
  endtask

  initial begin
    int lvl;
    int len;
    repeat (3) step(1'b0, 1'b0);
    repeat (5) step(1'b0, 1'b1);
    check_eq("reset_out", int'(db_out), 0);
    check_eq("reset_busy", int'(db_busy), 0);

    measure("press", 1'b1);
    repeat (10) step(1'b1, 1'b1);
    check_eq("press_hold", int'(db_out), 1);
    measure("release", 1'b0);
    repeat (10) step(1'b0, 1'b1);

    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    check_eq("bounce_quiet", int'(db_out), 0);
    measure("bounce", 1'b1);
    repeat (5) step(1'b1, 1'b1);

    step(1'b1, 1'b0);
    check_eq("rst_hi_out", int'(db_out), 0);
    repeat (CM + L + 3) step(1'b0, 1'b1);
    repeat (L + 3) step(1'b1, 1'b1);
    check_eq("midwait_busy", int'(db_busy), 1);
    step(1'b1, 1'b0);
    check_eq("rst_wait_out", int'(db_out), 0);
    check_eq("rst_wait_busy", int'(db_busy), 0);
    measure("after_rst", 1'b1);

    for (int seg = 0; seg < 400; seg++) begin
      lvl = int'($urandom % 2);
      len = int'($urandom_range(1, CM + 4));
      for (int i = 0; i < len; i++) begin
        step(lvl[0], ($urandom % 60) != 0);
      end
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d expected 0",
               sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
